// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// uart_tx_feeder_if: push, status and TX-handshake bundle   (rev 1.0)
// ---------------------------------------------------------------------
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ovf_clr;
  logic                  tx_sent;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_send;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  busy;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_sent,
    input  tx_data, tx_send, full, empty, level, overflow, busy
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_sent,
    output tx_data, tx_send, full, empty, level, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------
// uart_tx_feeder: byte FIFO + start/done sequencer for UART TX (rev 1.0)
// ---------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  uart_tx_feeder_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   C_LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = C_LVL_ONE[ADDR_WIDTH-1:0];

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SEND       = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   level_q;
  logic [ADDR_WIDTH:0]   level_d;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_send_q;
  logic                  busy_q;
  logic                  overflow_q;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full  = (level_q == C_LVL_FULL);
  assign empty = (level_q == '0);
  assign pop   = (state_q == LOAD);
  // A same-cycle pop frees a slot, so a push at full is still accepted.
  assign push  = bus.wr_en && (!full || pop);
  assign drop  = bus.wr_en && full && !pop;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + C_LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - C_LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_data_q  <= '0;
      tx_send_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      tx_send_q <= 1'b0;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end

      // tx_send_q/busy_q track the state being entered, so they act as Moore outputs.
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          tx_data_q <= mem_q[rd_ptr_q];
          rd_ptr_q  <= rd_ptr_q + C_PTR_ONE;
          state_q   <= SEND;
          tx_send_q <= 1'b1;
        end
        SEND: begin
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (!bus.tx_sent) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_sent) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_uart_tx_feeder: scoreboard bench with a simple UART TX model (rev 1.0)
// ---------------------------------------------------------------------
module tb_uart_tx_feeder;
  localparam int TX_FRAME = 20;

  logic clk = 1'b0;
  logic rst;
  logic tx_hold;
  int   tx_cnt;

  uart_tx_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // TX model: leaves idle right after a start pulse, finishes TX_FRAME cycles later
  // unless tx_hold stretches the frame.
  always @(negedge clk) begin
    if (!rst) begin
      bus.tx_sent = 1'b1;
      tx_cnt      = 0;
    end else if (bus.tx_send) begin
      bus.tx_sent = 1'b0;
      tx_cnt      = TX_FRAME;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
    end else if (!tx_hold) begin
      bus.tx_sent = 1'b1;
    end
  end

  logic [7:0] exp_q[$];
  int         n_cmp   = 0;
  int         n_err   = 0;
  int         n_sends = 0;
  logic       prev_send = 1'b0;
  logic       prev_rst  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst && prev_rst) begin
      if (bus.tx_send) begin
        n_sends++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: tx_send with tx_data=%02h, no byte expected", bus.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.tx_data !== exp_b) begin
            n_err++;
            $display("FAIL sb_data: tx_data=%02h expected %02h", bus.tx_data, exp_b);
          end
        end
        n_cmp++;
        if (prev_send) begin
          n_err++;
          $display("FAIL send_width: tx_send high 2 cycles, expected 1");
        end
      end else begin
        n_cmp++;
        if (bus.tx_data !== prev_data) begin
          n_err++;
          $display("FAIL data_stable: tx_data=%02h changed from %02h outside LOAD", bus.tx_data, prev_data);
        end
      end
    end
    prev_send = bus.tx_send;
    prev_data = bus.tx_data;
    prev_rst  = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    rst = 1'b0;
    repeat (2) tick();
    got = {bus.empty, bus.full, bus.level, bus.tx_send, bus.busy, bus.overflow, bus.tx_data};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: {empty,full,level,send,busy,ovf,data}=%h expected %h",
               got, {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [6:0] st;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    bus.wr_en = 1'b0;
    st = {bus.empty, bus.level, bus.busy};
    n_cmp++;
    if (st !== {1'b0, 5'd1, 1'b0} || bus.tx_send !== 1'b0) begin
      n_err++;
      $display("FAIL single_e0: {empty,level,busy}=%h send=%b expected %h send=0", st, bus.tx_send, {1'b0, 5'd1, 1'b0});
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.tx_send !== 1'b0) begin
      n_err++;
      $display("FAIL single_e1: busy=%b send=%b expected busy=1 send=0", bus.busy, bus.tx_send);
    end
    tick();
    n_cmp++;
    if (bus.tx_send !== 1'b1 || bus.tx_data !== 8'hA5 || bus.level !== 5'd0) begin
      n_err++;
      $display("FAIL single_e2: send=%b data=%02h level=%0d expected 1/a5/0", bus.tx_send, bus.tx_data, bus.level);
    end
    tick();
    n_cmp++;
    if (bus.tx_send !== 1'b0 || bus.tx_data !== 8'hA5) begin
      n_err++;
      $display("FAIL single_e3: send=%b data=%02h expected 0/a5", bus.tx_send, bus.tx_data);
    end
    for (int i = 0; i < 100 && bus.busy; i++) tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.tx_data !== 8'hA5 || bus.empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: busy=%b data=%02h empty=%b expected 0/a5/1", bus.busy, bus.tx_data, bus.empty);
    end
  endtask

  task automatic test_burst();
    logic [6:0] st;
    tx_hold     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    bus.wr_en = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (bus.level !== 5'd0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL burst_prime: level=%0d busy=%b expected 0/1", bus.level, bus.busy);
    end
    for (int i = 0; i < 16; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    bus.wr_en = 1'b0;
    st = {bus.full, bus.empty, bus.level};
    n_cmp++;
    if (st !== {1'b1, 1'b0, 5'd16}) begin
      n_err++;
      $display("FAIL burst_full: {full,empty,level}=%h expected %h", st, {1'b1, 1'b0, 5'd16});
    end
  endtask

  task automatic test_overflow();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.level !== 5'd16 || bus.full !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: ovf=%b level=%0d full=%b expected 1/16/1", bus.overflow, bus.level, bus.full);
    end
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.level !== 5'd16) begin
      n_err++;
      $display("FAIL ovf_clr: ovf=%b level=%0d expected 0/16", bus.overflow, bus.level);
    end
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    bus.ovf_clr = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_priority: ovf=%b expected 1 (set beats clear)", bus.overflow);
    end
    tick();
    bus.ovf_clr = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr2: ovf=%b expected 0", bus.overflow);
    end
  endtask

  task automatic test_simultaneous();
    repeat (25) tick();
    n_cmp++;
    if (bus.level !== 5'd16 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL sim_hold: level=%0d busy=%b expected 16/1", bus.level, bus.busy);
    end
    // Release: tx_sent rises at the next negedge -> IDLE, LOAD, then the pop edge.
    tx_hold = 1'b0;
    tick();
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    exp_q.push_back(8'h77);
    tick();
    bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.level !== 5'd16 || bus.overflow !== 1'b0 || bus.tx_send !== 1'b1) begin
      n_err++;
      $display("FAIL sim_push: level=%0d ovf=%b send=%b expected 16/0/1", bus.level, bus.overflow, bus.tx_send);
    end
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || bus.busy); i++) tick();
    n_cmp++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0 || bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      n_err++;
      $display("FAIL drain: pending=%0d busy=%b empty=%b level=%0d expected 0/0/1/0",
               exp_q.size(), bus.busy, bus.empty, bus.level);
    end
  endtask

  task automatic test_midframe_reset();
    logic [17:0] got;
    int          sends_before;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
      tick();
    end
    bus.wr_en = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if (bus.level !== 5'd5 || bus.busy !== 1'b1 || bus.tx_sent !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pre: level=%0d busy=%b tx_sent=%b expected 5/1/0", bus.level, bus.busy, bus.tx_sent);
    end
    rst = 1'b0;
    tick();
    got = {bus.empty, bus.full, bus.level, bus.tx_send, bus.busy, bus.overflow, bus.tx_data};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL mid_reset: {empty,full,level,send,busy,ovf,data}=%h expected %h",
               got, {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    exp_q.delete();
    sends_before = n_sends;
    rst = 1'b1;
    repeat (60) tick();
    n_cmp++;
    if (n_sends != sends_before || bus.busy !== 1'b0 || bus.empty !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after: sends=%0d busy=%b empty=%b expected sends=%0d busy=0 empty=1",
               n_sends - sends_before, bus.busy, bus.empty, 0);
    end
  endtask

  initial begin
    rst         = 1'b0;
    tx_hold     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
